// File: rtl/spm_access_controller_pkg.sv
// Shared definitions for the scratchpad front-end controller.
// Holds the access size encodings, the controller state enum, the SPM
// geometry and small helpers for lane selection and alignment checks.
package spm_access_controller_pkg;

  localparam int SPM_ADDR_W = 11;
  localparam int DATA_W     = 32;
  localparam int CPU_ADDR_W = 13;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DMA  = 1'b1
  } state_e;

  // Half at an odd offset, word at any non-zero offset and the reserved
  // size are all refused.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = offset[0];
      SIZE_WORD: is_misaligned = (offset != 2'b00);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

  // Big-endian lanes: byte offset k lives in lane 3-k.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: lane_mask = 4'b1000 >> offset;
      SIZE_HALF: lane_mask = offset[1] ? 4'b0011 : 4'b1100;
      default:   lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/spm_access_controller_load_align.sv
// spm_load_align: picks the addressed lane(s) out of a raw SPM word and
// zero- or sign-extends them to 32 bits.
// Ports:
//   size      in  2   registered access size
//   offset    in  2   registered byte offset within the word
//   is_signed in  1   registered sign-extend request
//   raw       in  32  word returned by the SPM
//   aligned   out 32  right-justified, extended load result
module spm_load_align
  import spm_access_controller_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Lane 3-k starts at bit 8*(3-k); for a 2-bit k, 3-k is simply ~k.
    byte_sel = raw[{~offset, 3'b000} +: 8];
    half_sel = offset[1] ? raw[15:0] : raw[31:16];
    case (size)
      SIZE_BYTE: aligned = {{24{is_signed & byte_sel[7]}}, byte_sel};
      SIZE_HALF: aligned = {{16{is_signed & half_sel[15]}}, half_sel};
      default:   aligned = raw;
    endcase
  end

endmodule

// File: rtl/spm_access_controller.sv
// spm_access_controller: CPU load/store front end and block-fill DMA for
// the 2048 x 32 data scratchpad.
// Ports:
//   clock, resetN                 clock and asynchronous active-low reset
//   cpuRequest/We/Size/Signed     CPU access request and attributes
//   cpuAddress[12:0], cpuDataIn   byte address and right-justified store data
//   cpuBusy                       request not accepted this cycle
//   cpuDataValid, cpuDataOut      load result, one cycle after acceptance
//   cpuMisaligned                 one-cycle pulse after a refused access
//   dmaStart/WordAddress/Length   block fill command
//   dmaDataValid/Data, dmaDataReady  fill data handshake
//   dmaActive, dmaDone            fill in progress / completion pulse
//   spmByteWe/Address/DataIn      SPM write enables, word address, data
//   spmDataOut                    SPM read data (one-cycle latency)
module spm_access_controller
  import spm_access_controller_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  cpuRequest,
  input  logic                  cpuWe,
  input  logic [1:0]            cpuSize,
  input  logic                  cpuSigned,
  input  logic [CPU_ADDR_W-1:0] cpuAddress,
  input  logic [DATA_W-1:0]     cpuDataIn,
  output logic                  cpuBusy,
  output logic                  cpuDataValid,
  output logic [DATA_W-1:0]     cpuDataOut,
  output logic                  cpuMisaligned,
  input  logic                  dmaStart,
  input  logic [SPM_ADDR_W-1:0] dmaWordAddress,
  input  logic [SPM_ADDR_W-1:0] dmaLength,
  input  logic                  dmaDataValid,
  input  logic [DATA_W-1:0]     dmaData,
  output logic                  dmaDataReady,
  output logic                  dmaActive,
  output logic                  dmaDone,
  output logic [3:0]            spmByteWe,
  output logic [SPM_ADDR_W-1:0] spmAddress,
  output logic [DATA_W-1:0]     spmDataIn,
  input  logic [DATA_W-1:0]     spmDataOut
);

  state_e                state_reg, state_next;
  logic [SPM_ADDR_W-1:0] dma_addr_reg;
  logic [SPM_ADDR_W-1:0] dma_remaining_reg;
  logic                  load_pending_reg;
  logic [1:0]            load_size_reg;
  logic [1:0]            load_offset_reg;
  logic                  load_signed_reg;
  logic                  misaligned_reg;
  logic                  dma_done_reg;

  logic                  busy;
  logic                  cpu_accept;
  logic                  access_bad;
  logic                  dma_beat;
  logic                  dma_last;
  logic                  dma_empty_start;
  logic [DATA_W-1:0]     store_data;
  logic [DATA_W-1:0]     load_aligned;

  // A DMA start in IDLE takes priority over a same-cycle CPU request.
  assign busy            = (state_reg == ST_DMA) || dmaStart;
  assign cpu_accept      = cpuRequest && !busy;
  assign access_bad      = is_misaligned(cpuSize, cpuAddress[1:0]);
  assign dma_beat        = (state_reg == ST_DMA) && dmaDataValid;
  assign dma_last        = dma_beat && (dma_remaining_reg == 11'd1);
  assign dma_empty_start = (state_reg == ST_IDLE) && dmaStart && (dmaLength == '0);

  // Replicate the right-justified store data across every lane; the byte
  // enables decide which copy actually lands.
  always_comb begin
    case (cpuSize)
      SIZE_BYTE: store_data = {4{cpuDataIn[7:0]}};
      SIZE_HALF: store_data = {2{cpuDataIn[15:0]}};
      default:   store_data = cpuDataIn;
    endcase
  end

  spm_load_align u_load_align (
    .size      (load_size_reg),
    .offset    (load_offset_reg),
    .is_signed (load_signed_reg),
    .raw       (spmDataOut),
    .aligned   (load_aligned)
  );

  // State register
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (dmaStart && (dmaLength != '0)) state_next = ST_DMA;
      ST_DMA:  if (dma_last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cpuBusy       = busy;
    cpuDataValid  = load_pending_reg;
    cpuDataOut    = load_pending_reg ? load_aligned : '0;
    cpuMisaligned = misaligned_reg;
    dmaDone       = dma_done_reg;
    dmaActive     = 1'b0;
    dmaDataReady  = 1'b0;
    spmByteWe     = 4'b0000;
    spmAddress    = '0;
    spmDataIn     = '0;
    case (state_reg)
      ST_IDLE: begin
        if (cpu_accept && !access_bad) begin
          spmAddress = cpuAddress[12:2];
          if (cpuWe) begin
            spmByteWe = lane_mask(cpuSize, cpuAddress[1:0]);
            spmDataIn = store_data;
          end
        end
      end
      ST_DMA: begin
        dmaActive    = 1'b1;
        dmaDataReady = 1'b1;
        if (dmaDataValid) begin
          spmByteWe  = 4'b1111;
          spmAddress = dma_addr_reg;
          spmDataIn  = dmaData;
        end
      end
      default: ;
    endcase
  end

  // CPU side: pending-load attributes and the misalignment pulse.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      load_pending_reg <= 1'b0;
      load_size_reg    <= 2'b00;
      load_offset_reg  <= 2'b00;
      load_signed_reg  <= 1'b0;
      misaligned_reg   <= 1'b0;
    end else begin
      load_pending_reg <= cpu_accept && !cpuWe && !access_bad;
      misaligned_reg   <= cpu_accept && access_bad;
      if (cpu_accept) begin
        load_size_reg   <= cpuSize;
        load_offset_reg <= cpuAddress[1:0];
        load_signed_reg <= cpuSigned;
      end
    end
  end

  // DMA pointer, remaining count and completion pulse.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      dma_addr_reg      <= '0;
      dma_remaining_reg <= '0;
      dma_done_reg      <= 1'b0;
    end else begin
      dma_done_reg <= dma_empty_start || dma_last;
      if ((state_reg == ST_IDLE) && dmaStart) begin
        dma_addr_reg      <= dmaWordAddress;
        dma_remaining_reg <= dmaLength;
      end else if (dma_beat) begin
        dma_addr_reg      <= dma_addr_reg + 11'd1;
        dma_remaining_reg <= dma_remaining_reg - 11'd1;
      end
    end
  end

endmodule

// File: tb/tb_spm_access_controller.sv
// Bench for spm_access_controller: directed scenarios followed by random
// CPU traffic and short fills, checked against a byte-addressed memory model.
module tb_spm_access_controller;

  logic        clock = 1'b0;
  logic        resetN;
  logic        cpuRequest, cpuWe, cpuSigned;
  logic [1:0]  cpuSize;
  logic [12:0] cpuAddress;
  logic [31:0] cpuDataIn;
  logic        cpuBusy, cpuDataValid, cpuMisaligned;
  logic [31:0] cpuDataOut;
  logic        dmaStart, dmaDataValid;
  logic [10:0] dmaWordAddress, dmaLength;
  logic [31:0] dmaData;
  logic        dmaDataReady, dmaActive, dmaDone;
  logic [3:0]  spmByteWe;
  logic [10:0] spmAddress;
  logic [31:0] spmDataIn, spmDataOut;

  spm_access_controller dut (
    .clock(clock), .resetN(resetN),
    .cpuRequest(cpuRequest), .cpuWe(cpuWe), .cpuSize(cpuSize), .cpuSigned(cpuSigned),
    .cpuAddress(cpuAddress), .cpuDataIn(cpuDataIn), .cpuBusy(cpuBusy),
    .cpuDataValid(cpuDataValid), .cpuDataOut(cpuDataOut), .cpuMisaligned(cpuMisaligned),
    .dmaStart(dmaStart), .dmaWordAddress(dmaWordAddress), .dmaLength(dmaLength),
    .dmaDataValid(dmaDataValid), .dmaData(dmaData), .dmaDataReady(dmaDataReady),
    .dmaActive(dmaActive), .dmaDone(dmaDone), .spmByteWe(spmByteWe),
    .spmAddress(spmAddress), .spmDataIn(spmDataIn), .spmDataOut(spmDataOut)
  );

  always #5 clock = ~clock;

  // SPM itself: byte-lane writes, one-cycle registered read.
  logic [31:0] spm_mem [0:2047];
  logic [31:0] spm_rdata = 32'h0;
  always @(posedge clock) begin
    for (int l = 0; l < 4; l++)
      if (spmByteWe[l]) spm_mem[spmAddress][8*l +: 8] <= spmDataIn[8*l +: 8];
    spm_rdata <= spm_mem[spmAddress];
  end
  assign spmDataOut = spm_rdata;

  // Reference: flat byte memory, byte address a holds the a-th byte in
  // big-endian order, so word w is bytes 4w..4w+3 from most significant.
  logic [7:0]  exp_mem [0:8191];
  logic        exp_valid, exp_mis, exp_done;
  logic [31:0] exp_data;
  int          dma_ptr, dma_left;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  // Advance one clock and check everything that is registered.
  task automatic tick();
    @(posedge clock);
    #1;
    chk("data_valid", {31'b0, cpuDataValid}, {31'b0, exp_valid});
    chk("data_out", cpuDataOut, exp_valid ? exp_data : 32'h0);
    chk("misaligned", {31'b0, cpuMisaligned}, {31'b0, exp_mis});
    chk("dma_done", {31'b0, dmaDone}, {31'b0, exp_done});
    exp_valid = 1'b0;
    exp_mis   = 1'b0;
    exp_done  = 1'b0;
  endtask

  task automatic quiet_inputs();
    cpuRequest = 1'b0; cpuWe = 1'b0; cpuSize = 2'b00; cpuSigned = 1'b0;
    cpuAddress = '0; cpuDataIn = '0;
    dmaStart = 1'b0; dmaWordAddress = '0; dmaLength = '0;
    dmaDataValid = 1'b0; dmaData = '0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    resetN = 1'b0;
    #1;
    chk("rst_busy", {31'b0, cpuBusy}, 32'h0);
    chk("rst_valid", {31'b0, cpuDataValid}, 32'h0);
    chk("rst_data_out", cpuDataOut, 32'h0);
    chk("rst_misaligned", {31'b0, cpuMisaligned}, 32'h0);
    chk("rst_dma_active", {31'b0, dmaActive}, 32'h0);
    chk("rst_dma_ready", {31'b0, dmaDataReady}, 32'h0);
    chk("rst_dma_done", {31'b0, dmaDone}, 32'h0);
    chk("rst_byte_we", {28'b0, spmByteWe}, 32'h0);
    chk("rst_spm_addr", {21'b0, spmAddress}, 32'h0);
    chk("rst_spm_data", spmDataIn, 32'h0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    exp_valid = 1'b0; exp_mis = 1'b0; exp_done = 1'b0;
    dma_ptr = 0; dma_left = 0;
  endtask

  task automatic idle();
    quiet_inputs();
    #1;
    chk("idle_byte_we", {28'b0, spmByteWe}, 32'h0);
    chk("idle_dma_active", {31'b0, dmaActive}, 32'h0);
    chk("idle_busy", {31'b0, cpuBusy}, 32'h0);
  endtask

  task automatic cpu_access(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [12:0] addr, input logic [31:0] data);
    int          n;
    int          lane;
    logic        mis;
    logic [3:0]  mask;
    logic [7:0]  b;
    logic [63:0] val;
    quiet_inputs();
    cpuRequest = 1'b1; cpuWe = we; cpuSize = size; cpuSigned = sgn;
    cpuAddress = addr; cpuDataIn = data;
    #1;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis = (size == 2'd3) || ((int'(addr) % n) != 0);
    chk("cpu_busy", {31'b0, cpuBusy}, 32'h0);
    if (mis) begin
      chk("mis_byte_we", {28'b0, spmByteWe}, 32'h0);
      exp_mis = 1'b1;
    end else begin
      chk("spm_addr", {21'b0, spmAddress}, {21'b0, addr[12:2]});
      if (we) begin
        mask = 4'b0000;
        for (int i = 0; i < n; i++) begin
          lane = 3 - ((int'(addr) + i) % 4);
          mask[lane] = 1'b1;
          b = 8'(data >> (8 * (n - 1 - i)));
          chk("store_lane", {24'b0, spmDataIn[8*lane +: 8]}, {24'b0, b});
          exp_mem[int'(addr) + i] = b;
        end
        chk("store_byte_we", {28'b0, spmByteWe}, {28'b0, mask});
      end else begin
        chk("load_byte_we", {28'b0, spmByteWe}, 32'h0);
        val = '0;
        for (int i = 0; i < n; i++) val = (val << 8) | 64'(exp_mem[int'(addr) + i]);
        if (sgn && val[8*n-1]) val = val | (64'hFFFF_FFFF_FFFF_FFFF << (8 * n));
        exp_valid = 1'b1;
        exp_data  = val[31:0];
      end
    end
  endtask

  task automatic dma_start(input int addr, input int len, input logic req);
    quiet_inputs();
    dmaStart = 1'b1; dmaWordAddress = 11'(addr); dmaLength = 11'(len);
    cpuRequest = req; cpuWe = 1'b1; cpuSize = 2'd2; cpuAddress = 13'h0040;
    cpuDataIn = 32'hDEAD_BEEF;
    #1;
    chk("start_busy", {31'b0, cpuBusy}, 32'h1);
    chk("start_byte_we", {28'b0, spmByteWe}, 32'h0);
    dma_ptr  = addr;
    dma_left = len;
    if (len == 0) exp_done = 1'b1;
  endtask

  task automatic dma_beat(input logic valid, input logic [31:0] data, input logic req);
    quiet_inputs();
    cpuRequest = req; cpuWe = 1'b1; cpuSize = 2'd2; cpuAddress = 13'h0040;
    cpuDataIn = 32'hDEAD_BEEF;
    dmaDataValid = valid; dmaData = data;
    // A stray start must be ignored while the fill runs.
    dmaStart = req; dmaWordAddress = 11'd7; dmaLength = 11'd9;
    #1;
    chk("dma_busy", {31'b0, cpuBusy}, 32'h1);
    chk("dma_active", {31'b0, dmaActive}, 32'h1);
    chk("dma_ready", {31'b0, dmaDataReady}, 32'h1);
    if (valid) begin
      chk("dma_byte_we", {28'b0, spmByteWe}, 32'hF);
      chk("dma_addr", {21'b0, spmAddress}, 32'(dma_ptr));
      chk("dma_wdata", spmDataIn, data);
      for (int i = 0; i < 4; i++) exp_mem[4*dma_ptr + i] = 8'(data >> (8 * (3 - i)));
      dma_ptr = (dma_ptr + 1) % 2048;
      dma_left--;
      if (dma_left == 0) exp_done = 1'b1;
    end else begin
      chk("dma_stall_we", {28'b0, spmByteWe}, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, len;
    for (int i = 0; i < 2048; i++) spm_mem[i] = 32'h0;
    for (int i = 0; i < 8192; i++) exp_mem[i] = 8'h0;
    exp_valid = 1'b0; exp_mis = 1'b0; exp_done = 1'b0; exp_data = '0;
    quiet_inputs();
    resetN = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    // Byte store, then signed and unsigned reloads back-to-back.
    cpu_access(1'b1, 2'd0, 1'b0, 13'h0006, 32'h0000_00A5); tick();
    cpu_access(1'b0, 2'd0, 1'b1, 13'h0006, 32'h0); tick();
    cpu_access(1'b0, 2'd0, 1'b0, 13'h0006, 32'h0); tick();
    // Half store at offset 0, then word and signed-half loads.
    cpu_access(1'b1, 2'd1, 1'b0, 13'h0010, 32'h0000_8001); tick();
    cpu_access(1'b0, 2'd2, 1'b0, 13'h0010, 32'h0); tick();
    cpu_access(1'b0, 2'd1, 1'b1, 13'h0010, 32'h0); tick();
    // Refused accesses.
    cpu_access(1'b0, 2'd2, 1'b0, 13'h0011, 32'h0); tick();
    idle(); tick();
    cpu_access(1'b1, 2'd1, 1'b0, 13'h0013, 32'h0000_1234); tick();
    cpu_access(1'b1, 2'd3, 1'b0, 13'h0020, 32'h1234_5678); tick();

    // Load accepted, fill started next cycle: load still completes.
    cpu_access(1'b0, 2'd2, 1'b0, 13'h0010, 32'h0); tick();
    dma_start(2046, 4, 1'b1); tick();
    dma_beat(1'b1, 32'd1, 1'b1); tick();
    dma_beat(1'b0, 32'd0, 1'b1); tick();
    dma_beat(1'b1, 32'd2, 1'b1); tick();
    dma_beat(1'b1, 32'd3, 1'b1); tick();
    dma_beat(1'b1, 32'd4, 1'b1); tick();
    idle(); tick();
    cpu_access(1'b0, 2'd2, 1'b0, 13'h1FF8, 32'h0); tick();
    cpu_access(1'b0, 2'd2, 1'b0, 13'h1FFC, 32'h0); tick();
    cpu_access(1'b0, 2'd2, 1'b0, 13'h0000, 32'h0); tick();
    cpu_access(1'b0, 2'd2, 1'b0, 13'h0004, 32'h0); tick();

    // Zero-length fill with a competing CPU request.
    dma_start(5, 0, 1'b1); tick();
    idle(); tick();

    // Reset in the middle of a fill.
    dma_start(100, 5, 1'b0); tick();
    dma_beat(1'b1, 32'h1111_1111, 1'b0); tick();
    dma_beat(1'b1, 32'h2222_2222, 1'b0); tick();
    do_reset();
    idle(); tick();
    idle(); tick();
    cpu_access(1'b0, 2'd2, 1'b0, 13'(400), 32'h0); tick();
    cpu_access(1'b0, 2'd2, 1'b0, 13'(404), 32'h0); tick();
    cpu_access(1'b0, 2'd2, 1'b0, 13'(408), 32'h0); tick();

    // Random traffic over a small window so stores and loads collide.
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 29));
      if (r == 0) begin
        idle(); tick();
      end else if (r == 1) begin
        len = int'($urandom_range(1, 3));
        dma_start(int'($urandom_range(0, 15)), len, 1'($urandom_range(0, 1))); tick();
        for (int k = 0; k < len; k++) begin
          dma_beat(1'b1, $urandom, 1'b1); tick();
        end
        idle(); tick();
      end else begin
        cpu_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 13'($urandom_range(0, 63)), $urandom);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
